// File: rtl/if_stage_pkg.sv
// Shared pipeline constants for the fetch stage and the stage registers.
package if_stage_pkg;
    localparam int          XLEN       = 32;
    localparam int          IM_AW_C    = 10;
    localparam logic [31:0] PC_RESET_C = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP    = 32'h0000_0004;
    localparam logic [31:0] LINK_OFS   = 32'h0000_0008;
    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;
endpackage

// File: rtl/if_stage_id_reg.sv
// IF/ID pipeline register: reset, then flush, then stall, then load.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc8_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc8_o,
    output logic            valid_o
);
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc8_q;
    logic            valid_q;

    // Stage register update; flush produces a bubble even while stalled.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0000_0000;
            pc8_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else if (stall_i) begin
            instr_q <= instr_q;
            pc_q    <= pc_q;
            pc8_q   <= pc8_q;
            valid_q <= valid_q;
        end else begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            pc8_q   <= pc8_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign pc8_o   = pc8_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/if_stage.sv
// MIPS fetch stage: PC register, next-PC selection and IF/ID capture.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_C,
    parameter int          IM_AW    = IM_AW_C
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_en,
    input  logic [31:0]      redirect_pc,
    input  logic             flush_d,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_instr,
    output logic [31:0]      pc_f,
    output logic [31:0]      instr_d,
    output logic [31:0]      pc_d,
    output logic [31:0]      pc8_d,
    output logic             valid_d
);
    logic [31:0] pc_f_q;
    logic [31:0] pc_f_d;
    logic [31:0] pc8_f_s;

    // Next-PC select: a stalled redirect is re-presented by decode next cycle.
    always_comb begin
        pc_f_d = pc_f_q;
        if (stall) begin
            pc_f_d = pc_f_q;
        end else if (redirect_en) begin
            pc_f_d = redirect_pc & WORD_MASK;
        end else begin
            pc_f_d = pc_f_q + PC_STEP;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q <= PC_RESET;
        end else begin
            pc_f_q <= pc_f_d;
        end
    end

    assign pc8_f_s = pc_f_q + LINK_OFS;
    assign im_addr = pc_f_q[IM_AW+1:2];
    assign pc_f    = pc_f_q;

    if_id_reg u_if_id (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush_d),
        .stall_i (stall),
        .instr_i (im_instr),
        .pc_i    (pc_f_q),
        .pc8_i   (pc8_f_s),
        .instr_o (instr_d),
        .pc_o    (pc_d),
        .pc8_o   (pc8_d),
        .valid_o (valid_d)
    );
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Fetch stage of the 5-stage MIPS pipeline.
- Owns the program counter and drives the word address of the instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for the decode stage.
- Honours decode-stage stall and redirect (branch/jump, delay-slot semantics: no squash of the slot instruction).

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset
IM_AW, 10, instruction-memory word-address width (IM covers 2^IM_AW words)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID this cycle
redirect_en  in  1  decode stage: next PC is redirect_pc (taken branch, j, jal, jr)
redirect_pc  in  32  redirect target from decode
flush_d  in  1  clear IF/ID to a bubble at this edge
im_addr  out  IM_AW  instruction-memory word address (pc_f[IM_AW+1:2])
im_instr  in  32  instruction returned combinationally by the IM for im_addr
pc_f  out  32  current fetch PC
instr_d  out  32  IF/ID: instruction
pc_d  out  32  IF/ID: PC of instr_d
pc8_d  out  32  IF/ID: pc_d + 8 (link value for jal/jalr)
valid_d  out  1  IF/ID holds a real fetched instruction

Behaviour:
- Reset (reset=1 at an edge, regardless of other inputs):
  - pc_f = PC_RESET.
  - instr_d = 32'h0000_0000 (nop), pc_d = 0, pc8_d = 0, valid_d = 0.
  - Reset asserted mid-stall or mid-redirect discards both.
- im_addr = pc_f[IM_AW+1:2], purely combinational. IM read is zero-latency, so instr for pc_f is available in the same cycle.
- Next PC priority, at each edge with reset=0:
  - stall=1: pc_f holds.
  - else redirect_en=1: pc_f <= {redirect_pc[31:2], 2'b00}. redirect_pc[1:0] is ignored; pc_f[1:0] is always 00.
  - else: pc_f <= pc_f + 4.
- IF/ID register, at each edge with reset=0:
  - flush_d=1: instr_d = 0, pc_d = 0, pc8_d = 0, valid_d = 0. Flush beats stall.
  - else stall=1: all IF/ID fields hold.
  - else: instr_d <= im_instr, pc_d <= pc_f, pc8_d <= pc_f + 8, valid_d <= 1.
- Stall together with redirect_en: stall wins. Decode is also stalled and re-presents the redirect next cycle; no redirect may be lost or applied twice.
- Delay slot: the instruction fetched in the cycle redirect_en is asserted is the slot instruction. It enters IF/ID normally unless flush_d is set.
- Arithmetic:
  - PC adds are 32-bit modulo, with 0xFFFF_FFFC + 4 wrapping to 0.
  - IM addressing wraps naturally within 2^IM_AW words. PC_RESET maps to word 0 when PC_RESET[IM_AW+1:2] = 0.
- No other state. Latency from redirect_en to the new pc_f is 1 edge, and the target instruction reaches instr_d 1 edge later.

Decomposition:
- Shared package (pipeline constants): PC_RESET value, NOP encoding 32'h0, IM_AW, instruction width 32.
- One natural sub-module: if_id_reg, the IF/ID register with flush/stall/reset priority, reused pattern for later stage registers.
- The PC register and next-PC mux stay inline in if_stage.

Test Plan:
- Reset, then 3 free-running cycles, IM preloaded with word i = 32'h1000_0000+i:
  - pc_f goes 0x3000, 0x3004, 0x3008, 0x300C.
  - instr_d goes 0x10000000, 0x10000001, 0x10000002 one edge behind.
  - pc8_d = pc_d+8.
- stall=1 for 2 cycles at pc_f=0x3008: pc_f stays 0x3008 and instr_d/pc_d stay 0x10000001/0x3004; fetch resumes at 0x300C after release.
- redirect_en=1, redirect_pc=0x3043 at pc_f=0x3010:
  - next pc_f = 0x3040.
  - Slot instr 0x10000004 appears in instr_d, followed by 0x10000010 (pc_d=0x3040).
- stall=1 and redirect_en=1 (target 0x3100) in the same cycle, then redirect_en held one more cycle with stall=0: pc_f holds, then becomes 0x3100 exactly once.
- flush_d=1 with stall=1: instr_d=0 and valid_d=0, pc_f holds. Then reset=1 mid-redirect: pc_f=0x3000 and IF/ID cleared on that edge.
